// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder for the pipeline MEM stage.
// Captures a load/store, completes it LATENCY cycles later, and stalls the pipeline meanwhile.
module data_memory_responder #(
  parameter int unsigned SIZE    = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Error,
  output logic        Stall
);

  localparam int unsigned WORDS = SIZE / 4;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit          DIRECT = (LATENCY == 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_write;
  logic          r_fault;
  logic [IW-1:0] r_index;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [WORDS];

  logic          w_req;
  logic          w_fault_in;
  logic [IW-1:0] w_index_in;
  logic          w_enter_done;
  logic          w_acc_write;
  logic          w_acc_fault;
  logic [IW-1:0] w_acc_index;
  logic [31:0]   w_acc_wdata;
  logic          w_mem_we;
  logic          w_mem_re;

  assign w_req      = ReadEnable | WriteEnable;
  assign w_fault_in = (Address[1:0] != 2'b00) | (Address >= SIZE) | (ReadEnable & WriteEnable);
  assign w_index_in = Address[IW+1:2];

  assign w_enter_done = (DIRECT && (r_state == ST_IDLE) && w_req) ||
                        ((r_state == ST_WAIT) && (r_count == '0));

  // With LATENCY=1 the access happens on the capture edge, so use the live request.
  always_comb begin
    w_acc_write = r_write;
    w_acc_fault = r_fault;
    w_acc_index = r_index;
    w_acc_wdata = r_wdata;
    if (r_state == ST_IDLE) begin
      w_acc_write = WriteEnable;
      w_acc_fault = w_fault_in;
      w_acc_index = w_index_in;
      w_acc_wdata = WriteData;
    end
  end

  assign w_mem_we = w_enter_done & w_acc_write & ~w_acc_fault & ~reset;
  assign w_mem_re = w_enter_done & ~w_acc_write & ~w_acc_fault & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_write <= 1'b0;
      r_fault <= 1'b0;
      r_index <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_write <= WriteEnable;
            r_fault <= w_fault_in;
            r_index <= w_index_in;
            r_wdata <= WriteData;
            r_count <= CNT_INIT;
            r_state <= DIRECT ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_count == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_mem_re) begin
        r_rdata <= r_mem[w_acc_index];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_acc_index] <= w_acc_wdata;
    end
  end

  assign ReadData = r_rdata;
  assign Ready    = (r_state == ST_DONE);
  assign Error    = Ready & r_fault;
  assign Stall    = w_req & ~Ready;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a LATENCY=2 instance and a LATENCY=1 instance
// share the request inputs.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;

  logic [31:0] rd1, rd2;
  logic        rdy1, rdy2, err1, err2, stall1, stall2;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.SIZE(4096), .LATENCY(2)) dut1 (
    .clock(clock), .reset(reset), .ReadEnable(re), .WriteEnable(we), .Address(addr),
    .WriteData(wd), .ReadData(rd1), .Ready(rdy1), .Error(err1), .Stall(stall1)
  );

  data_memory_responder #(.SIZE(4096), .LATENCY(1)) dut2 (
    .clock(clock), .reset(reset), .ReadEnable(re), .WriteEnable(we), .Address(addr),
    .WriteData(wd), .ReadData(rd2), .Ready(rdy2), .Error(err2), .Stall(stall2)
  );

  // Issues one request on instance sel (1 or 2) and waits, bounded, for its Ready pulse.
  // Entered and left at posedge+1.
  task automatic run_op(input int sel, input logic i_re, input logic i_we,
                        input logic [31:0] i_addr, input logic [31:0] i_wd,
                        output int n_stall, output logic got, output logic e,
                        output logic [31:0] d, output logic stall_done);
    logic r, s;
    re = i_re; we = i_we; addr = i_addr; wd = i_wd;
    n_stall = 0; got = 1'b0; e = 1'b0; d = '0; stall_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      r = (sel == 2) ? rdy2 : rdy1;
      s = (sel == 2) ? stall2 : stall1;
      if (r) begin
        got = 1'b1;
        e = (sel == 2) ? err2 : err1;
        d = (sel == 2) ? rd2 : rd1;
        stall_done = s;
        break;
      end
      if (s) n_stall++;
      @(posedge clock); #1;
    end
    re = 1'b0; we = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd1); end
      checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", rdy1); end
      checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", err1); end
      checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall1); end
    end
  endtask

  task automatic test_write_read();
    int n; logic g, e, sd; logic [31:0] d;
    run_op(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, n, g, e, d, sd);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", g); end
    checks++; if (n != 3) begin errors++; $display("FAIL wr_stall_cycles: got %0d want 3", n); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL wr_stall_done: got %b want 0", sd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_error: got %b want 0", e); end
    run_op(1, 1'b1, 1'b0, 32'h10, 32'h0, n, g, e, d, sd);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", g); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", d); end
    checks++; if (n != 3) begin errors++; $display("FAIL rd_stall_cycles: got %0d want 3", n); end
  endtask

  task automatic test_back_to_back();
    int n, np, t1, t2; logic g, e, sd; logic [31:0] d;
    run_op(1, 1'b0, 1'b1, 32'h0, 32'h11111111, n, g, e, d, sd);
    run_op(1, 1'b0, 1'b1, 32'h4, 32'h22222222, n, g, e, d, sd);
    np = 0; t1 = 0; t2 = 0;
    re = 1'b1; addr = 32'h0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (rdy1) begin
        if (np == 0) begin
          t1 = c;
          checks++; if (rd1 !== 32'h11111111) begin errors++; $display("FAIL b2b_first: got %h want 11111111", rd1); end
          addr = 32'h4;
        end else begin
          t2 = c;
          checks++; if (rd1 !== 32'h22222222) begin errors++; $display("FAIL b2b_second: got %h want 22222222", rd1); end
          re = 1'b0;
        end
        np++;
      end else if (np == 1) begin
        checks++; if (rd1 !== 32'h11111111) begin errors++; $display("FAIL b2b_hold: got %h want 11111111", rd1); end
      end
      if (np == 2) break;
      @(posedge clock); #1;
    end
    re = 1'b0;
    @(posedge clock); #1;
    checks++; if (np != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", np); end
    checks++; if (t2 - t1 != 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", t2 - t1); end
  endtask

  task automatic test_faults();
    int n; logic g, e, sd; logic [31:0] d;
    run_op(1, 1'b1, 1'b0, 32'h6, 32'h0, n, g, e, d, sd);
    checks++; if ({g, e} !== 2'b11) begin errors++; $display("FAIL misaligned_flags: got %b want 11", {g, e}); end
    checks++; if (d !== 32'h22222222) begin errors++; $display("FAIL misaligned_rd: got %h want 22222222", d); end
    run_op(1, 1'b0, 1'b1, 32'h1000, 32'hBAD0BAD0, n, g, e, d, sd);
    checks++; if ({g, e} !== 2'b11) begin errors++; $display("FAIL range_flags: got %b want 11", {g, e}); end
    checks++; if (d !== 32'h22222222) begin errors++; $display("FAIL range_rd: got %h want 22222222", d); end
    run_op(1, 1'b1, 1'b1, 32'h4, 32'h99999999, n, g, e, d, sd);
    checks++; if ({g, e} !== 2'b11) begin errors++; $display("FAIL both_flags: got %b want 11", {g, e}); end
    checks++; if (d !== 32'h22222222) begin errors++; $display("FAIL both_rd: got %h want 22222222", d); end
    run_op(1, 1'b1, 1'b0, 32'h0, 32'h0, n, g, e, d, sd);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL post_fault_err0: got %b want 0", e); end
    checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL post_fault_mem0: got %h want 11111111", d); end
    run_op(1, 1'b1, 1'b0, 32'h4, 32'h0, n, g, e, d, sd);
    checks++; if (d !== 32'h22222222) begin errors++; $display("FAIL post_fault_mem4: got %h want 22222222", d); end
  endtask

  task automatic test_reset_abort();
    int n, seen; logic g, e, sd; logic [31:0] d;
    run_op(1, 1'b0, 1'b1, 32'h20, 32'h12345678, n, g, e, d, sd);
    we = 1'b1; addr = 32'h20; wd = 32'hCAFEF00D;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; we = 1'b0;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL abort_rd_cleared: got %h want 0", rd1); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rdy1) seen++;
      @(posedge clock); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_ready: got %0d want 0", seen); end
    run_op(1, 1'b1, 1'b0, 32'h20, 32'h0, n, g, e, d, sd);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL abort_read_ready: got %b want 1", g); end
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL abort_old_value: got %h want 12345678", d); end
  endtask

  task automatic test_latency1();
    int n; logic g, e, sd; logic [31:0] d;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    run_op(2, 1'b0, 1'b1, 32'h30, 32'h5A5A1234, n, g, e, d, sd);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL lat1_wr_ready: got %b want 1", g); end
    checks++; if (n != 1) begin errors++; $display("FAIL lat1_wr_stall: got %0d want 1", n); end
    run_op(2, 1'b1, 1'b0, 32'h30, 32'h0, n, g, e, d, sd);
    checks++; if (n != 1) begin errors++; $display("FAIL lat1_rd_stall: got %0d want 1", n); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL lat1_stall_done: got %b want 0", sd); end
    checks++; if (d !== 32'h5A5A1234) begin errors++; $display("FAIL lat1_rd_data: got %h want 5a5a1234", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lat1_error: got %b want 0", e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_faults();
    test_reset_abort();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
